// File: rtl/counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | counter_pkg                                                                |
// | Shared mode constants and helpers for the up/down modulus counters.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // True when the modulus fits a WIDTH-bit register and has at least two states.
    function automatic bit modulus_ok(input int width, input int modulus);
        return (modulus >= 2) && (modulus <= (1 << width));
    endfunction

    function automatic bit mode_ok(input int mode);
        return (mode == MODE_WRAP) || (mode == MODE_SAT);
    endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/mod_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mod_updown_counter                                                         |
// | Modulo-N up/down counter with load, wrap/saturate modes and cascade tc.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] C_MAX      = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] C_ZERO     = '0;
    localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);
    localparam bit               C_SAT_MODE = (SATURATE == MODE_SAT);

    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("mod_updown_counter: MODULUS=%0d outside 2..2**WIDTH (WIDTH=%0d)",
               MODULUS, WIDTH);
    end

    if (!mode_ok(SATURATE)) begin : g_bad_mode
        $error("mod_updown_counter: SATURATE=%0d is not MODE_WRAP or MODE_SAT",
               SATURATE);
    end

    logic             w_at_top;
    logic             w_at_bot;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_wrap;
    logic             w_next_sat;

    assign w_at_top = (count == C_MAX);
    assign w_at_bot = (count == C_ZERO);

    // Zero-latency terminal count so a following stage counts on the same edge.
    assign tc = en & ((up & w_at_top) | (~up & w_at_bot));

    always_comb begin
        w_next_count = count;
        w_next_wrap  = 1'b0;
        w_next_sat   = sat;
        if (load) begin
            w_next_count = (din > C_MAX) ? C_MAX : din;
            w_next_sat   = 1'b0;
        end else if (en) begin
            if (up) begin
                if (!w_at_top) begin
                    w_next_count = count + C_ONE;
                    w_next_sat   = 1'b0;
                end else if (C_SAT_MODE) begin
                    w_next_sat   = 1'b1;
                end else begin
                    w_next_count = C_ZERO;
                    w_next_wrap  = 1'b1;
                    w_next_sat   = 1'b0;
                end
            end else begin
                if (!w_at_bot) begin
                    w_next_count = count - C_ONE;
                    w_next_sat   = 1'b0;
                end else if (C_SAT_MODE) begin
                    w_next_sat   = 1'b1;
                end else begin
                    w_next_count = C_MAX;
                    w_next_wrap  = 1'b1;
                    w_next_sat   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            count <= C_ZERO;
            wrap  <= 1'b0;
            sat   <= 1'b0;
        end else begin
            count <= w_next_count;
            wrap  <= w_next_wrap;
            sat   <= w_next_sat;
        end
    end

endmodule : mod_updown_counter
`default_nettype wire
